cpu_trace_buffer: RTL and testbench
===================================

// Module: cpu_trace_buffer
// PURPOSE
//  Synthesizable per-cycle commit-trace capture for the single-cycle CPU.
//  Each traced cycle records {pc, instr, next_pc} into a DEPTH-entry buffer.
//  Capture is trigger-armed and bounded by a cycle limit.
//  Entries drain through a valid/ready read port to a debug UART or scan reader.
//  Sits beside Simple_Single_CPU; taps PC output, instruction and next-PC mux.
// PARAMETERS
//  DATA_W      32   width of pc, instr and next_pc fields
//  DEPTH       16   buffer entries; power of 2, >= 2
//  CYCLE_LIMIT 560  captured cycles before auto-stop; 0 = unlimited
//  WRAP_MODE   0    0 = drop new entries when full; 1 = overwrite oldest when full
// PORTS
//  clk_i       in   1         core clock, rising edge
//  rst_i       in   1         asynchronous reset, active-low
//  clear_i     in   1         sync clear: pointers, flags, counter -> IDLE
//  trc_valid_i in   1         CPU retired an instruction this cycle
//  pc_i        in   DATA_W    PC of the retired instruction
//  instr_i     in   DATA_W    instruction word
//  next_pc_i   in   DATA_W    selected next PC
//  trig_en_i   in   1         1: arm on trig_pc_i; 0: start on first trc_valid_i
//  trig_pc_i   in   DATA_W    trigger PC
//  rd_ready_i  in   1         reader accepts rd_data_o
//  rd_valid_o  out  1         buffer non-empty
//  rd_data_o   out  3*DATA_W  {pc,instr,next_pc} of oldest entry, show-ahead
//  count_o     out  log2(DEPTH)+1  entries held
//  full_o      out  1         count_o == DEPTH
//  overflow_o  out  1         sticky: an entry was dropped or overwritten
//  cycle_cnt_o out  32        traced cycles since capture start
//  done_o      out  1         state == DONE
// BEHAVIOUR
//  Reset (rst_i=0, any time, async):
//   state=IDLE; wr/rd ptr=0; count_o=0; overflow_o=0; cycle_cnt_o=0.
//   RAM contents are not reset. rd_valid_o=0, so rd_data_o is don't-care.
//  FSM:
//   IDLE -> CAPTURE on trc_valid_i & (!trig_en_i | pc_i==trig_pc_i).
//     The triggering cycle itself is captured.
//   CAPTURE: every cycle with trc_valid_i pushes 1 entry; cycle_cnt_o +1 per pushed cycle.
//   CAPTURE -> DONE in the same edge on which cycle_cnt_o reaches CYCLE_LIMIT
//     (CYCLE_LIMIT>0). Exactly CYCLE_LIMIT pushes are attempted.
//   DONE: no pushes; reads continue. DONE -> IDLE only on clear_i or reset.
//   clear_i overrides all other events in its cycle.
//  Push/pop:
//   Write latency 1 cycle; entry visible on rd_data_o the cycle after the push.
//   Pop when rd_valid_o & rd_ready_i; rd_ptr advances at that edge.
//   rd_data_o = mem[rd_ptr], combinational from RAM.
//   Push+pop same cycle, not full: count unchanged, both pointers advance.
//   Push when full, WRAP_MODE=0: entry dropped; overflow_o<=1; ptrs unchanged.
//   Push when full, WRAP_MODE=1: write at wr_ptr; both ptrs advance; overflow_o<=1.
//   Push+pop when full: no loss, no overflow; both ptrs advance.
//   Pop when empty: ignored.
//   Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//   count_o is a separate counter and saturates at DEPTH.
//   cycle_cnt_o saturates at 2^32-1.
// STRUCTURE
//  Package cpu_trace_pkg:
//   - state encoding IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2
//   - ENTRY_W = 3*DATA_W helper
//   - clog2 function
//  Sub-module trace_fifo_mem:
//   - DEPTH x ENTRY_W, 1 sync write port, 1 async read port
//   - no reset
//  Top holds FSM, pointers, counters and flags.
// TESTING
//  1 Reset mid-capture (after 5 pushes): rst_i=0 for 1 cycle.
//    -> count_o=0, rd_valid_o=0, done_o=0, cycle_cnt_o=0.
//  2 trig_en_i=1, trig_pc_i=0x0C; PCs 0x00,04,08,0C,10 valid.
//    -> first popped entry pc=0x0C, count_o=2.
//  3 DEPTH=4, WRAP_MODE=0; push PCs 0,4,...,0x18 (7 entries), no reads.
//    -> full_o=1, overflow_o=1, pops yield 0,4,8,0xC.
//  4 DEPTH=4, WRAP_MODE=1; same stimulus.
//    -> pops yield 0xC,0x10,0x14,0x18; overflow_o=1.
//  5 Full buffer with push and pop in the same cycle.
//    -> count_o stays 4, overflow_o stays 0.
//  6 CYCLE_LIMIT=8, continuous trc_valid_i.
//    -> done_o=1 after 8th push; cycle_cnt_o=8.
//    -> further valid cycles add nothing; clear_i returns to IDLE.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared types and helpers for the CPU commit-trace buffer.
package cpu_trace_pkg;

    // Capture state machine encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } trc_state_e;

    // Each entry packs {pc, instr, next_pc}.
    localparam int FIELDS = 3;

    function automatic int entry_w(input int data_w);
        return FIELDS * data_w;
    endfunction

    // Ceiling log2, used for pointer and counter widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
module trace_fifo_mem import cpu_trace_pkg::*; #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 96
) (
    input  logic                    clk_i,
    input  logic                    we_i,
    input  logic [clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]        wdata_i,
    input  logic [clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]        rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is intentionally not reset; validity is tracked by the owner.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Trigger-armed, cycle-limited commit-trace capture with a valid/ready drain port.
module cpu_trace_buffer import cpu_trace_pkg::*; #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int CYCLE_LIMIT = 560,
    parameter int WRAP_MODE   = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    trc_valid_i,
    input  logic [DATA_W-1:0]       pc_i,
    input  logic [DATA_W-1:0]       instr_i,
    input  logic [DATA_W-1:0]       next_pc_i,
    input  logic                    trig_en_i,
    input  logic [DATA_W-1:0]       trig_pc_i,
    input  logic                    rd_ready_i,
    output logic                    rd_valid_o,
    output logic [3*DATA_W-1:0]     rd_data_o,
    output logic [clog2(DEPTH):0]   count_o,
    output logic                    full_o,
    output logic                    overflow_o,
    output logic [31:0]             cycle_cnt_o,
    output logic                    done_o
);

    localparam int AW      = clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = entry_w(DATA_W);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [31:0]   LIMIT_M1 = (CYCLE_LIMIT == 0) ? 32'd0 : 32'(CYCLE_LIMIT - 1);
    localparam logic          LIMITED  = (CYCLE_LIMIT != 0);
    localparam logic          WRAP     = (WRAP_MODE != 0);

    trc_state_e      state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [31:0]     cycle_cnt_q, cycle_cnt_d;

    logic            start;
    logic            push_req;
    logic            pop;
    logic            full;
    logic            wr_en;

    assign full     = (count_q == DEPTH_C);
    assign pop      = (count_q != '0) && rd_ready_i;
    assign start    = (state_q == IDLE) && trc_valid_i && (!trig_en_i || (pc_i == trig_pc_i));
    assign push_req = trc_valid_i && ((state_q == CAPTURE) || start);
    // A full buffer only takes the write if a slot frees this cycle or we overwrite.
    assign wr_en    = !clear_i && push_req && (!full || pop || WRAP);

    // Next-state logic for FSM, pointers, occupancy and sticky flags.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        cycle_cnt_d = cycle_cnt_q;

        if (clear_i) begin
            state_d     = IDLE;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            cycle_cnt_d = '0;
        end else begin
            if (push_req && full && !pop) begin
                // Full with no drain: either drop the newcomer or evict the oldest.
                overflow_d = 1'b1;
                if (WRAP) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
            end else begin
                if (push_req) begin
                    wr_ptr_d = wr_ptr_q + AW'(1);
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
                if (push_req && !pop) begin
                    count_d = count_q + CW'(1);
                end else if (pop && !push_req) begin
                    count_d = count_q - CW'(1);
                end
            end

            if (push_req && (cycle_cnt_q != '1)) begin
                cycle_cnt_d = cycle_cnt_q + 32'd1;
            end

            if (start) begin
                state_d = CAPTURE;
            end
            if (push_req && LIMITED && (cycle_cnt_q == LIMIT_M1)) begin
                state_d = DONE;
            end
        end
    end

    // State, pointer and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i ({pc_i, instr_i, next_pc_i}),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data_o)
    );

    assign rd_valid_o  = (count_q != '0);
    assign count_o     = count_q;
    assign full_o      = full;
    assign overflow_o  = overflow_q;
    assign cycle_cnt_o = cycle_cnt_q;
    assign done_o      = (state_q == DONE);

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: three configurations driven in parallel and
// compared every cycle against a queue-based reference model.
module tb_cpu_trace_buffer;

    localparam int DW  = 32;
    localparam int EW  = 96;
    localparam int DEP = 4;

    typedef logic [EW-1:0] ent_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          clear_i;
    logic          trc_valid_i;
    logic [DW-1:0] pc_i;
    logic [DW-1:0] instr_i;
    logic [DW-1:0] next_pc_i;
    logic          trig_en_i;
    logic [DW-1:0] trig_pc_i;
    logic          rd_ready_i;

    logic          rv   [3];
    logic [EW-1:0] rdat [3];
    logic [2:0]    cnt  [3];
    logic          fl   [3];
    logic          ovf  [3];
    logic [31:0]   cyc  [3];
    logic          dn   [3];

    // Reference model state per configuration
    ent_t   q0[$];
    ent_t   q1[$];
    ent_t   q2[$];
    int     mst  [3];
    bit     movf [3];
    longint mcyc [3];
    int     lim  [3] = '{0, 0, 8};
    bit     wrp  [3] = '{1'b0, 1'b1, 1'b0};

    int npass = 0;
    int ntot  = 0;

    always #5 clk_i = ~clk_i;

    cpu_trace_buffer #(.DATA_W(DW), .DEPTH(DEP), .CYCLE_LIMIT(0), .WRAP_MODE(0)) u_drop (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .trc_valid_i(trc_valid_i),
        .pc_i(pc_i), .instr_i(instr_i), .next_pc_i(next_pc_i), .trig_en_i(trig_en_i),
        .trig_pc_i(trig_pc_i), .rd_ready_i(rd_ready_i), .rd_valid_o(rv[0]),
        .rd_data_o(rdat[0]), .count_o(cnt[0]), .full_o(fl[0]), .overflow_o(ovf[0]),
        .cycle_cnt_o(cyc[0]), .done_o(dn[0]));

    cpu_trace_buffer #(.DATA_W(DW), .DEPTH(DEP), .CYCLE_LIMIT(0), .WRAP_MODE(1)) u_wrap (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .trc_valid_i(trc_valid_i),
        .pc_i(pc_i), .instr_i(instr_i), .next_pc_i(next_pc_i), .trig_en_i(trig_en_i),
        .trig_pc_i(trig_pc_i), .rd_ready_i(rd_ready_i), .rd_valid_o(rv[1]),
        .rd_data_o(rdat[1]), .count_o(cnt[1]), .full_o(fl[1]), .overflow_o(ovf[1]),
        .cycle_cnt_o(cyc[1]), .done_o(dn[1]));

    cpu_trace_buffer #(.DATA_W(DW), .DEPTH(DEP), .CYCLE_LIMIT(8), .WRAP_MODE(0)) u_lim (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .trc_valid_i(trc_valid_i),
        .pc_i(pc_i), .instr_i(instr_i), .next_pc_i(next_pc_i), .trig_en_i(trig_en_i),
        .trig_pc_i(trig_pc_i), .rd_ready_i(rd_ready_i), .rd_valid_o(rv[2]),
        .rd_data_o(rdat[2]), .count_o(cnt[2]), .full_o(fl[2]), .overflow_o(ovf[2]),
        .cycle_cnt_o(cyc[2]), .done_o(dn[2]));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Model one clock edge: 0=idle, 1=capturing, 2=done.
    task automatic model_step(inout ent_t q[$], input int m);
        bit push;
        bit pop;
        ent_t e;
        if (clear_i) begin
            q.delete();
            mst[m]  = 0;
            movf[m] = 1'b0;
            mcyc[m] = 0;
            return;
        end
        e    = {pc_i, instr_i, next_pc_i};
        pop  = (q.size() != 0) && rd_ready_i;
        push = trc_valid_i && (mst[m] == 1 || (mst[m] == 0 && (!trig_en_i || pc_i == trig_pc_i)));
        if (pop) void'(q.pop_front());
        if (push) begin
            if (q.size() < DEP) begin
                q.push_back(e);
            end else begin
                movf[m] = 1'b1;
                if (wrp[m]) begin
                    void'(q.pop_front());
                    q.push_back(e);
                end
            end
            if (mst[m] == 0) mst[m] = 1;
            if (mcyc[m] < 64'hFFFF_FFFF) mcyc[m]++;
            if (lim[m] > 0 && mcyc[m] == longint'(lim[m])) mst[m] = 2;
        end
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete(); q2.delete();
        for (int m = 0; m < 3; m++) begin
            mst[m] = 0; movf[m] = 1'b0; mcyc[m] = 0;
        end
    endtask

    task automatic check_one(input ent_t q[$], input int m);
        chk($sformatf("count[%0d]", m), 128'(cnt[m]), 128'(q.size()));
        chk($sformatf("rd_valid[%0d]", m), 128'(rv[m]), 128'(q.size() != 0));
        chk($sformatf("full[%0d]", m), 128'(fl[m]), 128'(q.size() == DEP));
        chk($sformatf("overflow[%0d]", m), 128'(ovf[m]), 128'(movf[m]));
        chk($sformatf("cycle_cnt[%0d]", m), 128'(cyc[m]), 128'(mcyc[m]));
        chk($sformatf("done[%0d]", m), 128'(dn[m]), 128'(mst[m] == 2));
        if (q.size() != 0) chk($sformatf("rd_data[%0d]", m), 128'(rdat[m]), 128'(q[0]));
    endtask

    task automatic check_all();
        check_one(q0, 0);
        check_one(q1, 1);
        check_one(q2, 2);
    endtask

    // Drive one cycle (inputs change on the falling edge), update models, check.
    task automatic step(input logic v, input logic [31:0] pc, input logic rdy, input logic clr);
        trc_valid_i = v;
        pc_i        = pc;
        instr_i     = $urandom();
        next_pc_i   = $urandom();
        rd_ready_i  = rdy;
        clear_i     = clr;
        @(posedge clk_i);
        model_step(q0, 0);
        model_step(q1, 1);
        model_step(q2, 2);
        @(negedge clk_i);
        check_all();
    endtask

    task automatic do_reset();
        trc_valid_i = 1'b0;
        rd_ready_i  = 1'b0;
        clear_i     = 1'b0;
        #2;
        rst_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        check_all();
        rst_i = 1'b1;
    endtask

    logic [31:0] exp_drop [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] exp_wrap [4] = '{32'hC, 32'h10, 32'h14, 32'h18};

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; trc_valid_i = 1'b0; pc_i = '0; instr_i = '0;
        next_pc_i = '0; trig_en_i = 1'b0; trig_pc_i = '0; rd_ready_i = 1'b0;
        @(negedge clk_i);
        do_reset();

        // Reset in the middle of a capture
        for (int i = 0; i < 5; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0);
        do_reset();
        chk("mid_rst_count", 128'(cnt[0]), 128'd0);
        chk("mid_rst_cyc", 128'(cyc[2]), 128'd0);

        // Trigger on PC 0x0C
        trig_en_i = 1'b1;
        trig_pc_i = 32'h0C;
        for (int i = 0; i < 5; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0);
        chk("trig_count", 128'(cnt[0]), 128'd2);
        chk("trig_first_pc", 128'(rdat[0][95:64]), 128'h0C);
        trig_en_i = 1'b0;
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Seven pushes into a four-entry buffer, then drain
        for (int i = 0; i < 7; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0);
        chk("drop_full", 128'(fl[0]), 128'd1);
        chk("drop_ovf", 128'(ovf[0]), 128'd1);
        chk("wrap_ovf", 128'(ovf[1]), 128'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drop_pop%0d", k), 128'(rdat[0][95:64]), 128'(exp_drop[k]));
            chk($sformatf("wrap_pop%0d", k), 128'(rdat[1][95:64]), 128'(exp_wrap[k]));
            step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        chk("drained", 128'(rv[0]), 128'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Full buffer with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h200 + 32'(i * 4), 1'b1, 1'b0);
            chk("pp_count", 128'(cnt[0]), 128'd4);
            chk("pp_ovf", 128'(ovf[0]), 128'd0);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);

        // Cycle limit of 8 on the third instance
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
            if (i == 7) begin
                chk("lim_done", 128'(dn[2]), 128'd1);
                chk("lim_cyc", 128'(cyc[2]), 128'd8);
            end
        end
        chk("lim_cyc_hold", 128'(cyc[2]), 128'd8);
        chk("unlim_cyc", 128'(cyc[0]), 128'd12);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("done_reads", 128'(cnt[2]), 128'd3);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("clear_done", 128'(dn[2]), 128'd0);

        // Randomized traffic with occasional triggers, clears and a reset
        for (int i = 0; i < 400; i++) begin
            trig_en_i = ($urandom_range(0, 3) == 0);
            trig_pc_i = 32'($urandom_range(0, 7) * 4);
            if (i == 200) do_reset();
            step(1'($urandom_range(0, 3) != 0), 32'($urandom_range(0, 7) * 4),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 39) == 0));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
